// File: rtl/display_pkg.sv
// Raster timing constants and shared types for the 1280x1024 DVI display path.
package display_pkg;

   localparam int COLOR_W = 8;
   localparam int CNT_W   = 11;

   localparam int DEF_H_ACTIVE = 1280;
   localparam int DEF_H_FP     = 48;
   localparam int DEF_H_SYNC   = 112;
   localparam int DEF_H_BP     = 248;
   localparam int DEF_V_ACTIVE = 1024;
   localparam int DEF_V_FP     = 1;
   localparam int DEF_V_SYNC   = 3;
   localparam int DEF_V_BP     = 38;
   localparam int DEF_PIPE     = 2;

   localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
   localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
   localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
   localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
   localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

   // Side-band that travels with each request; syncs are active-low.
   typedef struct packed {
      logic active;
      logic hsync;
      logic vsync;
   } sync_bus_t;

   localparam sync_bus_t SYNC_IDLE = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1};

   function automatic logic in_window(input logic [CNT_W-1:0] v,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register that keeps request-side sync/active flags aligned
// with the colour returning from the display pipeline.
module sync_delay #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned W = 3,
   parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_pass
         assign q = d;
      end else begin : g_shift
         logic [W-1:0] stage_r [DEPTH];

         // Shift chain; reset loads every stage with the idle pattern.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < int'(DEPTH); i++) begin
                  stage_r[i] <= RST_VAL;
               end
            end else begin
               stage_r[0] <= d;
               for (int i = 1; i < int'(DEPTH); i++) begin
                  stage_r[i] <= stage_r[i-1];
               end
            end
         end

         assign q = stage_r[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/dvi_timing_gen.sv
// Raster scan for the display: issues pixel requests, then re-times the returned
// colour with delayed syncs/data-enable for the DVI transmitter.
module dvi_timing_gen
   import display_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int PIPE     = DEF_PIPE
) (
   input  logic               clk,
   input  logic               reset,
   output logic [10:0]        x,
   output logic [9:0]         y,
   output logic               valid,
   output logic               vsync,
   output logic               frame_start,
   input  logic [COLOR_W-1:0] r,
   input  logic [COLOR_W-1:0] g,
   input  logic [COLOR_W-1:0] b,
   output logic [COLOR_W-1:0] dvi_r,
   output logic [COLOR_W-1:0] dvi_g,
   output logic [COLOR_W-1:0] dvi_b,
   output logic               dvi_hsync,
   output logic               dvi_vsync,
   output logic               dvi_de
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [CNT_W-1:0]   hc_r, vc_r;
   logic [CNT_W-1:0]   hc_next_s, vc_next_s;
   logic               hc_wrap_s;
   logic               active_s, hsync_s, vsync_s, first_s;

   logic [10:0]        x_r;
   logic [9:0]         y_r;
   logic               valid_r, hsync_r, vsync_r, frame_start_r;

   sync_bus_t          req_sync_s, dly_sync_s;

   logic [COLOR_W-1:0] dvi_r_r, dvi_g_r, dvi_b_r;
   logic               dvi_hsync_r, dvi_vsync_r, dvi_de_r;

   // Next counter state; vc only moves on the line wrap so vsync spans whole lines.
   always_comb begin
      hc_wrap_s = (hc_r == H_LAST);
      hc_next_s = hc_r + 11'd1;
      vc_next_s = vc_r;
      if (hc_wrap_s) begin
         hc_next_s = 11'd0;
         if (vc_r == V_LAST) begin
            vc_next_s = 11'd0;
         end else begin
            vc_next_s = vc_r + 11'd1;
         end
      end else begin
         vc_next_s = vc_r;
      end
   end

   // Raster counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hc_r <= 11'd0;
         vc_r <= 11'd0;
      end else begin
         hc_r <= hc_next_s;
         vc_r <= vc_next_s;
      end
   end

   // Region and sync decode of the current counter state.
   always_comb begin
      active_s = (hc_r < H_ACT_END) && (vc_r < V_ACT_END);
      hsync_s  = ~in_window(hc_r, HS_START, HS_END);
      vsync_s  = ~in_window(vc_r, VS_START, VS_END);
      first_s  = (hc_r == 11'd0) && (vc_r == 11'd0);
   end

   // Request-side registers; coordinates are forced to 0 outside the active area.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_r           <= 11'd0;
         y_r           <= 10'd0;
         valid_r       <= 1'b0;
         hsync_r       <= 1'b1;
         vsync_r       <= 1'b1;
         frame_start_r <= 1'b0;
      end else begin
         valid_r       <= active_s;
         hsync_r       <= hsync_s;
         vsync_r       <= vsync_s;
         frame_start_r <= first_s;
         if (active_s) begin
            x_r <= hc_r;
            y_r <= vc_r[9:0];
         end else begin
            x_r <= 11'd0;
            y_r <= 10'd0;
         end
      end
   end

   assign req_sync_s = '{active: valid_r, hsync: hsync_r, vsync: vsync_r};

   sync_delay #(
      .DEPTH   (PIPE),
      .W       (3),
      .RST_VAL (SYNC_IDLE)
   ) u_sync_delay (
      .clk   (clk),
      .reset (reset),
      .d     (req_sync_s),
      .q     (dly_sync_s)
   );

   // Output register: colour sampled in step with the delayed flags, masked in blanking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dvi_r_r     <= 8'd0;
         dvi_g_r     <= 8'd0;
         dvi_b_r     <= 8'd0;
         dvi_de_r    <= 1'b0;
         dvi_hsync_r <= 1'b1;
         dvi_vsync_r <= 1'b1;
      end else begin
         dvi_de_r    <= dly_sync_s.active;
         dvi_hsync_r <= dly_sync_s.hsync;
         dvi_vsync_r <= dly_sync_s.vsync;
         if (dly_sync_s.active) begin
            dvi_r_r <= r;
            dvi_g_r <= g;
            dvi_b_r <= b;
         end else begin
            dvi_r_r <= 8'd0;
            dvi_g_r <= 8'd0;
            dvi_b_r <= 8'd0;
         end
      end
   end

   assign x           = x_r;
   assign y           = y_r;
   assign valid       = valid_r;
   assign vsync       = vsync_r;
   assign frame_start = frame_start_r;
   assign dvi_r       = dvi_r_r;
   assign dvi_g       = dvi_g_r;
   assign dvi_b       = dvi_b_r;
   assign dvi_hsync   = dvi_hsync_r;
   assign dvi_vsync   = dvi_vsync_r;
   assign dvi_de      = dvi_de_r;

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Self-checking bench for dvi_timing_gen: full horizontal timing, vertical size
// shortened so whole frames fit in a short run.
module tb_dvi_timing_gen;

   localparam int H_ACTIVE = 1280, H_FP = 48, H_SYNC = 112, H_BP = 248;
   localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 3, V_BP = 2;
   localparam int PIPE = 2;
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int FRAME = H_TOTAL * V_TOTAL;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [10:0] x;
   logic [9:0]  y;
   logic        valid, vsync, frame_start;
   logic [7:0]  r = 8'hFF, g = 8'hFF, b = 8'hFF;
   logic [7:0]  dvi_r, dvi_g, dvi_b;
   logic        dvi_hsync, dvi_vsync, dvi_de;

   always #5 clk = ~clk;

   dvi_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .PIPE(PIPE)
   ) dut (
      .clk(clk), .reset(reset), .x(x), .y(y), .valid(valid), .vsync(vsync),
      .frame_start(frame_start), .r(r), .g(g), .b(b),
      .dvi_r(dvi_r), .dvi_g(dvi_g), .dvi_b(dvi_b),
      .dvi_hsync(dvi_hsync), .dvi_vsync(dvi_vsync), .dvi_de(dvi_de)
   );

   typedef struct packed {
      logic       de;
      logic [7:0] cr, cg, cb;
      logic       hs, vs;
   } dvi_t;

   typedef struct {
      int   tick;
      logic v;
      int   ex;
      int   ey;
      logic vs;
      logic fs;
   } vec_t;

   localparam dvi_t DVI_IDLE = '{de: 1'b0, cr: 8'd0, cg: 8'd0, cb: 8'd0, hs: 1'b1, vs: 1'b1};

   int   checks = 0, failures = 0;
   dvi_t sb[$];
   vec_t tbl[13];

   int   tick_n, mh, mv, cur_h, cur_v, phase, frames_seen;
   logic [10:0] hx[3];
   logic        hv[3];
   logic prev_valid, de_prev, hs_prev, vs_prev, vh_done, vl_done;
   int   run, de_fall_tick, hs_fall, vs_fall, fs_last;
   int   fs_period_checks = 0, hs_checks = 0, vs_checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (tick %0d phase %0d)", name, act, exp, tick_n, phase);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_req"}, {8'd0, valid, x, y, vsync, frame_start}, {8'd0, 1'b0, 11'd0, 10'd0, 1'b1, 1'b0});
      check({tag, "_dvi"}, {5'd0, dvi_de, dvi_r, dvi_g, dvi_b, dvi_hsync, dvi_vsync}, {5'd0, DVI_IDLE});
   endtask

   task automatic start_phase();
      tick_n = 0; mh = 0; mv = 0;
      sb.delete();
      for (int i = 0; i <= PIPE; i++) sb.push_back(DVI_IDLE);
      for (int i = 0; i < 3; i++) begin hx[i] = 11'd0; hv[i] = 1'b0; end
      r = 8'hFF; g = 8'hFF; b = 8'hFF;
      prev_valid = 1'b0; de_prev = 1'b0; hs_prev = 1'b1; vs_prev = 1'b1;
      vh_done = 1'b0; vl_done = 1'b0;
      run = 0; de_fall_tick = 0; hs_fall = 0; vs_fall = 0; fs_last = 0;
   endtask

   // One pixel clock: compare request and returned outputs after the edge, then drive the consumer.
   task automatic tick();
      logic        ea, ehs, evs, efs;
      logic [10:0] ex;
      logic [9:0]  ey;
      dvi_t        exp_d, act_d;
      @(negedge clk);
      tick_n++;
      cur_h = mh; cur_v = mv;
      ea  = (mh < H_ACTIVE) && (mv < V_ACTIVE);
      ehs = !((mh >= H_ACTIVE + H_FP) && (mh < H_ACTIVE + H_FP + H_SYNC));
      evs = !((mv >= V_ACTIVE + V_FP) && (mv < V_ACTIVE + V_FP + V_SYNC));
      efs = (mh == 0) && (mv == 0);
      ex  = ea ? 11'(mh) : 11'd0;
      ey  = ea ? 10'(mv) : 10'd0;
      check("req", {8'd0, valid, x, y, vsync, frame_start}, {8'd0, ea, ex, ey, evs, efs});

      exp_d = '{de: ea, cr: ea ? ex[7:0] : 8'd0, cg: ea ? ex[10:3] : 8'd0,
                cb: ea ? ~ex[7:0] : 8'd0, hs: ehs, vs: evs};
      sb.push_back(exp_d);
      act_d = '{de: dvi_de, cr: dvi_r, cg: dvi_g, cb: dvi_b, hs: dvi_hsync, vs: dvi_vsync};
      if (sb.size() == 0) check("dvi_sb_empty", 32'd1, 32'd0);
      else check("dvi", {5'd0, act_d}, {5'd0, sb.pop_front()});

      if (phase == 0) begin
         for (int i = 0; i < 13; i++) begin
            if (tbl[i].tick == tick_n)
               check($sformatf("vec%0d", i), {8'd0, valid, x, y, vsync, frame_start},
                     {8'd0, tbl[i].v, 11'(tbl[i].ex), 10'(tbl[i].ey), tbl[i].vs, tbl[i].fs});
         end
         if (efs && tick_n > 1) frames_seen++;
      end

      // Consumer: returns colour derived from x two requests ago; 8'hFF when that request was blank.
      hx[2] = hx[1]; hv[2] = hv[1];
      hx[1] = hx[0]; hv[1] = hv[0];
      hx[0] = x;     hv[0] = valid;
      r = hv[2] ? hx[2][7:0]  : 8'hFF;
      g = hv[2] ? hx[2][10:3] : 8'hFF;
      b = hv[2] ? ~hx[2][7:0] : 8'hFF;

      if (tick_n > 1 && valid !== prev_valid) begin
         if (!valid && !vh_done) begin check("valid_high_run", run, H_ACTIVE); vh_done = 1'b1; end
         else if (valid && vh_done && !vl_done) begin check("valid_low_run", run, H_TOTAL - H_ACTIVE); vl_done = 1'b1; end
         run = 0;
      end
      run++;
      prev_valid = valid;

      if (de_prev && !dvi_de) de_fall_tick = tick_n;
      if (hs_prev && !dvi_hsync) begin
         if (de_fall_tick > 0 && tick_n - de_fall_tick < H_TOTAL) check("hsync_start", tick_n - de_fall_tick, H_FP);
         hs_fall = tick_n;
      end
      if (!hs_prev && dvi_hsync && hs_fall > 0) begin check("hsync_width", tick_n - hs_fall, H_SYNC); hs_checks++; end
      if (vs_prev && !dvi_vsync) begin
         if (de_fall_tick > 0) check("vsync_start", tick_n - de_fall_tick, (H_TOTAL - H_ACTIVE) + H_TOTAL);
         vs_fall = tick_n;
      end
      if (!vs_prev && dvi_vsync && vs_fall > 0) begin check("vsync_width", tick_n - vs_fall, V_SYNC * H_TOTAL); vs_checks++; end
      if (frame_start === 1'b1) begin
         if (fs_last > 0) begin check("frame_start_period", tick_n - fs_last, FRAME); fs_period_checks++; end
         fs_last = tick_n;
      end
      de_prev = dvi_de; hs_prev = dvi_hsync; vs_prev = dvi_vsync;

      if (mh == H_TOTAL - 1) begin
         mh = 0;
         mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
      end else begin
         mh = mh + 1;
      end
   endtask

   initial begin
      logic done;
      // tick t shows counter state t-1: hc = (t-1) % H_TOTAL, vc = (t-1) / H_TOTAL
      tbl[0]  = '{1,                    1'b1, 0,    0, 1'b1, 1'b1};
      tbl[1]  = '{2,                    1'b1, 1,    0, 1'b1, 1'b0};
      tbl[2]  = '{1280,                 1'b1, 1279, 0, 1'b1, 1'b0};
      tbl[3]  = '{1281,                 1'b0, 0,    0, 1'b1, 1'b0};
      tbl[4]  = '{1688,                 1'b0, 0,    0, 1'b1, 1'b0};
      tbl[5]  = '{1689,                 1'b1, 0,    1, 1'b1, 1'b0};
      tbl[6]  = '{3 * 1688 + 1280,      1'b1, 1279, 3, 1'b1, 1'b0};
      tbl[7]  = '{4 * 1688 + 1,         1'b0, 0,    0, 1'b1, 1'b0};
      tbl[8]  = '{5 * 1688 + 1,         1'b0, 0,    0, 1'b0, 1'b0};
      tbl[9]  = '{8 * 1688,             1'b0, 0,    0, 1'b0, 1'b0};
      tbl[10] = '{8 * 1688 + 1,         1'b0, 0,    0, 1'b1, 1'b0};
      tbl[11] = '{16880,                1'b0, 0,    0, 1'b1, 1'b0};
      tbl[12] = '{16881,                1'b1, 0,    0, 1'b1, 1'b1};

      phase = 0; frames_seen = 0; tick_n = 0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_values("por");
      reset = 1'b0;
      start_phase();

      done = 1'b0;
      for (int n = 0; n < 30000 && !done; n++) begin
         tick();
         if (frames_seen == 1 && cur_h == 700 && cur_v == 2) done = 1'b1;
      end
      check("reset_point_reached", {31'd0, done}, 32'd1);

      // Mid-frame reset: outputs must return to idle asynchronously.
      reset = 1'b1;
      #1;
      check_reset_values("mid_rst_now");
      @(negedge clk);
      check_reset_values("mid_rst_hold");
      reset = 1'b0;
      phase = 1;
      start_phase();
      for (int n = 0; n < 4000; n++) begin
         tick();
         if (n == 0) check("restart_origin", {29'd0, valid, frame_start, (x == 11'd0 && y == 10'd0)}, 32'd7);
         if (n < PIPE + 1) check("de_low_after_reset", {31'd0, dvi_de}, 32'd0);
         else if (n == PIPE + 1) check("first_de_after_reset", {31'd0, dvi_de}, 32'd1);
      end

      check("frame_start_period_seen", {31'd0, fs_period_checks > 0}, 32'd1);
      check("hsync_width_seen", {31'd0, hs_checks > 0}, 32'd1);
      check("vsync_width_seen", {31'd0, vs_checks > 0}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dvi_timing_gen.md
# dvi_timing_gen

Raster timing generator and pixel return path for the 1280×1024 display. It scans the frame and issues pixel requests (`x`, `y`, `valid`, `vsync`) to the waveform display pipeline. It samples the `r`/`g`/`b` that pipeline returns a fixed number of cycles later, and drives the DVI transmitter with colour, syncs and data-enable aligned to that colour.

## Interface
Parameters:
- `H_ACTIVE`, 1280: visible pixels per line
- `H_FP`, `H_SYNC`, `H_BP`: 48, 112, 248; horizontal porch/sync widths in clocks
- `V_ACTIVE`, 1024: visible lines
- `V_FP`, `V_SYNC`, `V_BP`: 1, 3, 38; vertical porch/sync widths in lines
- `PIPE`, 2: cycles between a request and the consumer's matching `r`/`g`/`b` (0..7)

Ports:
- `clk` in 1: pixel clock
- `reset` in 1: asynchronous, active-high
- `x` out 11: request column, 0..1279; 0 when not `valid`
- `y` out 10: request row, 0..1023; 0 when not `valid`
- `valid` out 1: request is an active pixel
- `vsync` out 1: request-side vertical sync, active-low
- `frame_start` out 1: one-cycle pulse with request (0,0)
- `r`, `g`, `b` in 8 each: colour returned by the consumer
- `dvi_r`, `dvi_g`, `dvi_b` out 8 each: registered colour; 0 outside active
- `dvi_hsync`, `dvi_vsync` out 1 each: active-low, aligned with `dvi_*` colour
- `dvi_de` out 1: data enable, aligned with `dvi_*` colour

## Operation
- Internal counters `hc`, `vc`, 11 bits each.
- `H_TOTAL` = 1688 and `V_TOTAL` = 1066; frame = 1,799,408 clocks.
- `hc` increments every clock and wraps from `H_TOTAL`-1 to 0.
- `vc` increments only on the `hc` wrap, and wraps from `V_TOTAL`-1 to 0.
- Active region: `hc` < `H_ACTIVE` and `vc` < `V_ACTIVE`.
- Horizontal sync low: `hc` in [1328, 1440).
- Vertical sync low: `vc` in [1025, 1028). It changes only at the `hc` wrap, so each sync covers whole lines.
- Request outputs are a registered decode of the counters:
  - `valid` = active region
  - `x`/`y` = `hc`/`vc` when active, else 0
  - `vsync` = vertical sync decode
  - `frame_start` = (`hc`==0 && `vc`==0)
- Return path:
  - The request-side active, hsync and vsync decodes pass through a `PIPE`-stage shift register.
  - At the output register: `dvi_de` = delayed active; `dvi_r/g/b` = delayed active ? `r/g/b` : 0; `dvi_hsync`/`dvi_vsync` = delayed syncs.
- `r`/`g`/`b` are don't-care outside the active region. Colour is masked to 0 there regardless of input.

## Timing
- Reset values (immediate, asynchronous):
  - `hc`, `vc` = 0
  - `x`, `y`, `valid`, `frame_start` = 0; `vsync` = 1
  - all `dvi_*` colour = 0; `dvi_de` = 0; `dvi_hsync`, `dvi_vsync` = 1
  - every pipeline stage holds the inactive value
- First rising edge after reset deasserts: `valid`=1, `x`=0, `y`=0, `frame_start`=1.
- Request latency: counter state N appears on the request outputs one edge later.
- Return alignment:
  - For a request visible after edge k, `r`/`g`/`b` are sampled at edge k+`PIPE`+1.
  - `dvi_*` for that pixel is visible after that edge.
  - All `dvi_*` outputs are mutually aligned to within zero cycles.
- After reset the `dvi` outputs stay inactive for `PIPE`+1 cycles, then the first active pixel appears.
- Reset asserted mid-frame: all outputs return to reset values at once. After release the scan restarts at (0,0); no partial line is resumed.
- Simultaneous `hc` and `vc` wrap at (1687, 1065): the next state is (0,0) and `frame_start` fires.
- `x` never exceeds 1279 and `y` never exceeds 1023.

## Structure
- Shared package `display_pkg` holds:
  - the timing constants
  - derived `H_TOTAL`, `V_TOTAL`, and the sync start/end values
  - the colour width (8)
- One sub-module, `sync_delay`: a parameterised-depth shift register carrying {active, hsync, vsync}. The `PIPE`=0 case is a pass-through.
- Counters, decode and the output register stay in the top module.

## Test plan
- Reset release → first edge: `x`=0, `y`=0, `valid`=1, `frame_start`=1. `frame_start` recurs exactly 1,799,408 clocks later.
- One line: `valid` high for 1280 consecutive clocks, then low for 408. `vsync`=1 and `x` = 0 throughout the blank.
- Horizontal sync: delayed `dvi_hsync` is low for exactly 112 clocks, starting 48 clocks after `dvi_de` falls.
- Vertical sync: `dvi_vsync` is low for exactly 3×1688 clocks, starting one full line after the last active line.
- Colour return with `PIPE`=2 and a consumer driving `r` = `x`[7:0] two cycles late: `dvi_r` reads 0,1,2,…,255,0… from the first `dvi_de`. `dvi_r` = 0 whenever `dvi_de` = 0, even with `r` = 8'hFF.
- Reset pulse at `hc`=700, `vc`=500: outputs read reset values during the pulse. The scan restarts at (0,0) one edge after release, and `dvi_de` stays low for 3 cycles.
